serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder_cell.sv | 20 ++
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  assign ha1_s = a ^ b;
  assign ha1_c = a & b;
  assign s     = ha1_s ^ cin;
  assign ha2_c = ha1_s & cin;
  assign cout  = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] sum_sr_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             last_bit;
  logic             fa_s;
  logic             fa_cout;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  full_adder_cell u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        SHIFT: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          sum_sr_reg <= {fa_s, sum_sr_reg[WIDTH-1:1]};
          carry_reg  <= fa_cout;
          cnt_reg    <= cnt_reg + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign sum   = sum_sr_reg;
  assign carry = carry_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // On the MSB step carry_reg is the carry into the MSB and fa_cout the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == SHIFT && last_bit) begin
      ovf_reg <= carry_reg ^ fa_cout;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 (directed + random) and WIDTH=16 (random).
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        iv   [2];
  logic        ordy [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        cy   [2];
  logic [7:0]  a0, b0, sum0;
  logic [15:0] a1, b1, sum1;
  logic        ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  // Behavioural model: at most one operation in flight per instance.
  bit     busy    [2];
  int     edges   [2];
  longint exp_res [2];
  bit     exp_ovf [2];
  int     wd      [2] = '{8, 16};

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rstn[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a0), .b(b0), .sum(sum0), .carry(cy[0]), .out_valid(ov[0]), .out_ready(ordy[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf0)
`endif
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rstn[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a1), .b(b1), .sum(sum1), .carry(cy[1]), .out_valid(ov[1]), .out_ready(ordy[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s w%0d act=%0h exp=%0h t=%0t", nm, wd[i], act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    busy[i]  = 1'b0;
    edges[i] = 0;
  endtask

  task automatic model_step(input int i, input logic v, input longint x, input longint y,
                            input logic r);
    int     w = wd[i];
    longint m = (longint'(1) << w) - 1;
    longint s;
    if (busy[i]) begin
      if (edges[i] >= w && r) busy[i] = 1'b0;
      else edges[i]++;
    end else if (v) begin
      busy[i]    = 1'b1;
      edges[i]   = 0;
      s          = (x & m) + (y & m);
      exp_res[i] = s;
      exp_ovf[i] = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    end
  endtask

  always @(posedge clk or negedge rstn[0])
    if (!rstn[0]) model_reset(0);
    else model_step(0, iv[0], longint'(a0), longint'(b0), ordy[0]);

  always @(posedge clk or negedge rstn[1])
    if (!rstn[1]) model_reset(1);
    else model_step(1, iv[1], longint'(a1), longint'(b1), ordy[1]);

  task automatic compare(input int i, input logic r_in, input logic v_out,
                         input longint res, input logic of);
    bit exp_v = busy[i] && (edges[i] >= wd[i]);
    chk("in_ready", i, longint'(r_in), longint'(!busy[i]));
    chk("out_valid", i, longint'(v_out), longint'(exp_v));
    if (exp_v) begin
      chk("sum_carry", i, res, exp_res[i]);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", i, longint'(of), longint'(exp_ovf[i]));
`endif
    end
  endtask

  always @(negedge clk) begin
    compare(0, ir[0], ov[0], longint'({cy[0], sum0}), ovf0);
    compare(1, ir[1], ov[1], longint'({cy[1], sum1}), ovf1);
  end

  task automatic wait_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] x, input logic [15:0] y);
    if (i == 0) begin
      a0 = x[7:0];
      b0 = y[7:0];
    end else begin
      a1 = x;
      b1 = y;
    end
  endtask

  // Returns one time unit after the accept edge.
  task automatic start_op(input int i, input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    while (!ir[i] && n < 100) begin
      wait_cyc();
      n++;
    end
    if (!ir[i]) chk("accept_timeout", i, 0, 1);
    set_ops(i, x, y);
    iv[i] = 1'b1;
    wait_cyc();
    iv[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, output int n);
    n = 0;
    while (!ov[i] && n < 200) begin
      wait_cyc();
      n++;
    end
    if (!ov[i]) chk("valid_timeout", i, 0, 1);
  endtask

  task automatic finish_op(input int i);
    ordy[i] = 1'b1;
    wait_cyc();
    ordy[i] = 1'b0;
  endtask

  task automatic add8(input logic [7:0] x, input logic [7:0] y,
                      output logic [8:0] r, output logic of);
    int n;
    start_op(0, {8'h00, x}, {8'h00, y});
    wait_valid(0, n);
    r  = {cy[0], sum0};
    of = ovf0;
    finish_op(0);
    $display("w8 directed a=%h b=%h -> carry,sum=%h ovf=%0b", x, y, r, of);
  endtask

  task automatic random_sweep(input int i, input int n);
    logic [15:0] m = (i == 0) ? 16'h00FF : 16'hFFFF;
    logic [15:0] x, y;
    logic [16:0] res;
    bit          hs;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 7))
        0:       x = m;
        1:       x = '0;
        default: x = 16'($urandom) & m;
      endcase
      case ($urandom_range(0, 7))
        0:       y = m;
        1:       y = '0;
        default: y = 16'($urandom) & m;
      endcase
      start_op(i, x, y);
      hs  = 1'b0;
      res = '0;
      for (int c = 0; c < 300 && !hs; c++) begin
        ordy[i] = 1'($urandom_range(0, 1));
        hs      = ov[i] && ordy[i];
        res     = (i == 0) ? {8'h00, cy[0], sum0} : {cy[1], sum1};
        wait_cyc();
      end
      ordy[i] = 1'b0;
      if (!hs) chk("handshake_timeout", i, 0, 1);
      $display("w%0d txn %0d a=%h b=%h -> carry,sum=%h", wd[i], k, x, y, res);
    end
  endtask

  initial begin
    logic [8:0] r;
    logic       of;
    int         n;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0;
      iv[i]   = 1'b0;
      ordy[i] = 1'b0;
    end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 0, longint'(ir[0]), 1);
    chk("rst_out_valid", 0, longint'(ov[0]), 0);
    chk("rst_sum", 0, longint'(sum0), 0);
    chk("rst_carry", 0, longint'(cy[0]), 0);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    fork
      begin
        // First accept on the very next edge after reset release; 5+3.
        start_op(0, 16'h0005, 16'h0003);
        wait_valid(0, n);
        chk("latency_edges", 0, longint'(n), 8);
        chk("add_05_03", 0, longint'({cy[0], sum0}), 9'h008);
        $display("w8 directed a=05 b=03 -> carry,sum=%h after %0d edges", {cy[0], sum0}, n);
        // Result must hold while the consumer stalls.
        for (int c = 0; c < 5; c++) begin
          wait_cyc();
          chk("hold_valid", 0, longint'(ov[0]), 1);
          chk("hold_sum", 0, longint'({cy[0], sum0}), 9'h008);
          chk("hold_in_ready", 0, longint'(ir[0]), 0);
        end
        finish_op(0);
        chk("post_done_in_ready", 0, longint'(ir[0]), 1);
        chk("post_done_out_valid", 0, longint'(ov[0]), 0);

        add8(8'hFF, 8'h01, r, of);
        chk("add_ff_01", 0, longint'(r), 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_ff_01", 0, longint'(of), 0);
`endif
        add8(8'h7F, 8'h01, r, of);
        chk("add_7f_01", 0, longint'(r), 9'h080);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_7f_01", 0, longint'(of), 1);
`endif

        // A second in_valid during SHIFT must be ignored.
        start_op(0, 16'h0020, 16'h0031);
        repeat (3) wait_cyc();
        set_ops(0, 16'h0011, 16'h0011);
        iv[0] = 1'b1;
        wait_cyc();
        iv[0] = 1'b0;
        wait_valid(0, n);
        chk("ignore_in_valid", 0, longint'({cy[0], sum0}), 9'h051);
        $display("w8 directed a=20 b=31 (pulse 11) -> carry,sum=%h", {cy[0], sum0});
        finish_op(0);

        // Reset in the middle of SHIFT discards the operation.
        start_op(0, 16'h000F, 16'h000F);
        repeat (4) wait_cyc();
        rstn[0] = 1'b0;
        #1;
        chk("midrst_out_valid", 0, longint'(ov[0]), 0);
        chk("midrst_sum", 0, longint'(sum0), 0);
        chk("midrst_carry", 0, longint'(cy[0]), 0);
        chk("midrst_in_ready", 0, longint'(ir[0]), 1);
        wait_cyc();
        rstn[0] = 1'b1;
        add8(8'h3C, 8'h44, r, of);
        chk("add_after_rst", 0, longint'(r), 9'h080);

        random_sweep(0, 1000);
      end
      begin
        random_sweep(1, 1000);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
